// File: rtl/io_port_ctrl_if.sv
// Device-side and CPU-side signal bundle for io_port_ctrl.
// master = CPU/device view, slave = the controller.
`timescale 1ns/1ps
interface io_port_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] ext_in_data;
    logic              ext_in_valid;
    logic              ext_in_ready;
    logic [DATA_W-1:0] ext_out_data;
    logic              ext_out_valid;
    logic              ext_out_ready;
    logic              cpu_inp;
    logic [DATA_W-1:0] cpu_rd_data;
    logic              cpu_out;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              fgi;
    logic              fgo;
    logic              ion;
    logic              iof;
    logic              irq_ack;
    logic              ien;
    logic              irq;
    logic [CNT_W-1:0]  in_count;
    logic [CNT_W-1:0]  out_count;
    logic              err_ovf;
    logic              err_udf;
    logic              err_clr;

    modport master (
        output ext_in_data, ext_in_valid, ext_out_ready,
        output cpu_inp, cpu_out, cpu_wr_data,
        output ion, iof, irq_ack, err_clr,
        input  ext_in_ready, ext_out_data, ext_out_valid,
        input  cpu_rd_data, fgi, fgo, ien, irq,
        input  in_count, out_count, err_ovf, err_udf
    );

    modport slave (
        input  ext_in_data, ext_in_valid, ext_out_ready,
        input  cpu_inp, cpu_out, cpu_wr_data,
        input  ion, iof, irq_ack, err_clr,
        output ext_in_ready, ext_out_data, ext_out_valid,
        output cpu_rd_data, fgi, fgo, ien, irq,
        output in_count, out_count, err_ovf, err_udf
    );
endinterface

// File: rtl/io_port_ctrl.sv
// Buffered I/O port: device-to-CPU and CPU-to-device FIFOs with FGI/FGO flags,
// interrupt enable, occupancy counters and sticky overflow/underflow flags.
`timescale 1ns/1ps
module io_port_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic          clock,
    input  logic          reset,
    io_port_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("io_port_ctrl: DEPTH must be a power of 2 and at least 2");
    end

    logic [DATA_W-1:0] in_mem  [DEPTH];
    logic [PTR_W-1:0]  in_wr_ptr;
    logic [PTR_W-1:0]  in_rd_ptr;
    logic [CNT_W-1:0]  in_cnt;

    logic [DATA_W-1:0] out_mem [DEPTH];
    logic [PTR_W-1:0]  out_wr_ptr;
    logic [PTR_W-1:0]  out_rd_ptr;
    logic [CNT_W-1:0]  out_cnt;

    logic ien_q;
    logic ovf_q;
    logic udf_q;

    logic in_full, in_empty, in_push, in_pop;
    logic out_full, out_empty, out_push, out_pop;

    assign in_full   = (in_cnt == CNT_FULL);
    assign in_empty  = (in_cnt == '0);
    assign out_full  = (out_cnt == CNT_FULL);
    assign out_empty = (out_cnt == '0);

    // Handshake qualifiers only use registered full/empty, never the strobes.
    assign in_push  = bus.ext_in_valid & ~in_full;
    assign in_pop   = bus.cpu_inp & ~in_empty;
    assign out_push = bus.cpu_out & ~out_full;
    assign out_pop  = bus.ext_out_ready & ~out_empty;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) in_mem[i] <= '0;
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_cnt    <= '0;
        end else begin
            if (in_push) begin
                in_mem[in_wr_ptr] <= bus.ext_in_data;
                in_wr_ptr         <= in_wr_ptr + PTR_W'(1);
            end
            if (in_pop) in_rd_ptr <= in_rd_ptr + PTR_W'(1);
            case ({in_push, in_pop})
                2'b10:   in_cnt <= in_cnt + CNT_W'(1);
                2'b01:   in_cnt <= in_cnt - CNT_W'(1);
                default: in_cnt <= in_cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) out_mem[i] <= '0;
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_cnt    <= '0;
        end else begin
            if (out_push) begin
                out_mem[out_wr_ptr] <= bus.cpu_wr_data;
                out_wr_ptr          <= out_wr_ptr + PTR_W'(1);
            end
            if (out_pop) out_rd_ptr <= out_rd_ptr + PTR_W'(1);
            case ({out_push, out_pop})
                2'b10:   out_cnt <= out_cnt + CNT_W'(1);
                2'b01:   out_cnt <= out_cnt - CNT_W'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    // A new error event outranks err_clr in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ien_q <= 1'b0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.irq_ack)  ien_q <= 1'b0;
            else if (bus.iof) ien_q <= 1'b0;
            else if (bus.ion) ien_q <= 1'b1;

            if (bus.cpu_out & out_full) ovf_q <= 1'b1;
            else if (bus.err_clr)       ovf_q <= 1'b0;

            if (bus.cpu_inp & in_empty) udf_q <= 1'b1;
            else if (bus.err_clr)       udf_q <= 1'b0;
        end
    end

    assign bus.ext_in_ready  = ~in_full;
    assign bus.cpu_rd_data   = in_empty ? '0 : in_mem[in_rd_ptr];
    assign bus.fgi           = ~in_empty;
    assign bus.in_count      = in_cnt;

    assign bus.ext_out_valid = ~out_empty;
    assign bus.ext_out_data  = out_empty ? '0 : out_mem[out_rd_ptr];
    assign bus.fgo           = ~out_full;
    assign bus.out_count     = out_cnt;

    assign bus.ien     = ien_q;
    assign bus.irq     = ien_q & (~in_empty | ~out_full);
    assign bus.err_ovf = ovf_q;
    assign bus.err_udf = udf_q;
endmodule

// File: tb/tb_io_port_ctrl.sv
// Bench for io_port_ctrl: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based model of the port.
`timescale 1ns/1ps
module tb_io_port_ctrl;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic clock = 1'b0;
    logic reset;

    io_port_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    io_port_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // stimulus held for one cycle
    logic       t_rst, t_in_valid, t_inp, t_out, t_out_ready;
    logic       t_ion, t_iof, t_ack, t_clr;
    logic [7:0] t_in_data, t_wr_data;

    // reference model
    logic [7:0] m_in_q[$];
    logic [7:0] m_out_q[$];
    logic [7:0] rx_q[$];
    bit         m_ien, m_ovf, m_udf;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic idle();
        t_rst = 1'b1; t_in_valid = 1'b0; t_inp = 1'b0; t_out = 1'b0;
        t_out_ready = 1'b0; t_ion = 1'b0; t_iof = 1'b0; t_ack = 1'b0;
        t_clr = 1'b0; t_in_data = 8'h00; t_wr_data = 8'h00;
    endtask

    task automatic drive();
        reset             = t_rst;
        bus.ext_in_valid  = t_in_valid;
        bus.ext_in_data   = t_in_data;
        bus.cpu_inp       = t_inp;
        bus.cpu_out       = t_out;
        bus.cpu_wr_data   = t_wr_data;
        bus.ext_out_ready = t_out_ready;
        bus.ion           = t_ion;
        bus.iof           = t_iof;
        bus.irq_ack       = t_ack;
        bus.err_clr       = t_clr;
    endtask

    task automatic check_model();
        bit fgi_e, fgo_e;
        fgi_e = (m_in_q.size() != 0);
        fgo_e = (m_out_q.size() < DEPTH);
        chk("ext_in_ready",  32'(bus.ext_in_ready),  32'(m_in_q.size() < DEPTH));
        chk("cpu_rd_data",   32'(bus.cpu_rd_data),   fgi_e ? 32'(m_in_q[0]) : 32'd0);
        chk("fgi",           32'(bus.fgi),           32'(fgi_e));
        chk("in_count",      32'(bus.in_count),      32'(m_in_q.size()));
        chk("ext_out_valid", 32'(bus.ext_out_valid), 32'(m_out_q.size() != 0));
        chk("ext_out_data",  32'(bus.ext_out_data),  (m_out_q.size() != 0) ? 32'(m_out_q[0]) : 32'd0);
        chk("fgo",           32'(bus.fgo),           32'(fgo_e));
        chk("out_count",     32'(bus.out_count),     32'(m_out_q.size()));
        chk("ien",           32'(bus.ien),           32'(m_ien));
        chk("irq",           32'(bus.irq),           32'(m_ien && (fgi_e || fgo_e)));
        chk("err_ovf",       32'(bus.err_ovf),       32'(m_ovf));
        chk("err_udf",       32'(bus.err_udf),       32'(m_udf));
    endtask

    task automatic model_update();
        bit in_pop, in_push, out_pop, out_push, ovf_ev, udf_ev;
        if (!t_rst) begin
            m_in_q.delete();
            m_out_q.delete();
            m_ien = 0; m_ovf = 0; m_udf = 0;
            return;
        end
        in_pop   = t_inp && (m_in_q.size() != 0);
        in_push  = t_in_valid && (m_in_q.size() < DEPTH);
        udf_ev   = t_inp && (m_in_q.size() == 0);
        out_pop  = t_out_ready && (m_out_q.size() != 0);
        out_push = t_out && (m_out_q.size() < DEPTH);
        ovf_ev   = t_out && (m_out_q.size() == DEPTH);
        if (in_pop)   void'(m_in_q.pop_front());
        if (in_push)  m_in_q.push_back(t_in_data);
        if (out_pop)  void'(m_out_q.pop_front());
        if (out_push) m_out_q.push_back(t_wr_data);
        m_ovf = ovf_ev ? 1'b1 : (t_clr ? 1'b0 : m_ovf);
        m_udf = udf_ev ? 1'b1 : (t_clr ? 1'b0 : m_udf);
        if (t_ack)      m_ien = 0;
        else if (t_iof) m_ien = 0;
        else if (t_ion) m_ien = 1;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle();
        drive();
        check_model();
        if (bus.ext_out_valid && t_out_ready) rx_q.push_back(bus.ext_out_data);
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    initial begin
        idle();
        t_rst = 1'b0;
        drive();
        @(posedge clock);
        model_update();
        @(negedge clock);
        idle();
        cycle();
        chk("rst_in_count", 32'(bus.in_count), 32'd0);
        chk("rst_fgo", 32'(bus.fgo), 32'd1);
        chk("rst_ready", 32'(bus.ext_in_ready), 32'd1);

        // device fills input FIFO, fifth offer refused
        for (int i = 0; i < 4; i++) begin
            t_in_valid = 1'b1; t_in_data = 8'(8'h11 * (i + 1));
            cycle();
        end
        chk("s1_count", 32'(bus.in_count), 32'd4);
        chk("s1_ready", 32'(bus.ext_in_ready), 32'd0);
        chk("s1_fgi", 32'(bus.fgi), 32'd1);
        t_in_data = 8'h55;
        cycle();
        chk("s1_count_after_5th", 32'(bus.in_count), 32'd4);

        // CPU drains in order, then underflow
        idle();
        for (int i = 0; i < 4; i++) begin
            t_inp = 1'b1;
            chk("s2_rd", 32'(bus.cpu_rd_data), 32'(8'h11 * (i + 1)));
            cycle();
        end
        idle();
        chk("s2_fgi", 32'(bus.fgi), 32'd0);
        chk("s2_rd_empty", 32'(bus.cpu_rd_data), 32'd0);
        chk("s2_ready", 32'(bus.ext_in_ready), 32'd1);
        t_inp = 1'b1;
        cycle();
        idle();
        chk("s2_udf", 32'(bus.err_udf), 32'd1);
        chk("s2_count", 32'(bus.in_count), 32'd0);
        t_clr = 1'b1;
        cycle();
        idle();
        chk("s2_udf_clr", 32'(bus.err_udf), 32'd0);

        // output overflow then device drain
        for (int i = 0; i < 5; i++) begin
            t_out = 1'b1; t_wr_data = 8'(8'hA0 + i);
            cycle();
        end
        idle();
        chk("s3_count", 32'(bus.out_count), 32'd4);
        chk("s3_fgo", 32'(bus.fgo), 32'd0);
        chk("s3_ovf", 32'(bus.err_ovf), 32'd1);
        rx_q.delete();
        t_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("s3_rx_n", 32'(rx_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < rx_q.size(); i++)
            chk("s3_rx", 32'(rx_q[i]), 32'(8'hA0 + i));
        chk("s3_valid", 32'(bus.ext_out_valid), 32'd0);
        chk("s3_fgo_after", 32'(bus.fgo), 32'd1);
        idle();
        t_clr = 1'b1;
        cycle();
        idle();

        // simultaneous push/pop at count 2 through pointer wrap
        for (int i = 0; i < 2; i++) begin
            t_in_valid = 1'b1; t_in_data = 8'(i + 1);
            cycle();
        end
        for (int i = 0; i < 10; i++) begin
            t_in_valid = 1'b1; t_in_data = 8'(8'h10 + i); t_inp = 1'b1;
            chk("s4_head", 32'(bus.cpu_rd_data), (i < 2) ? 32'(i + 1) : 32'(8'h10 + i - 2));
            cycle();
            chk("s4_count", 32'(bus.in_count), 32'd2);
        end
        idle();
        t_inp = 1'b1;
        cycle(); cycle();
        idle();

        // interrupt enable priority
        t_ion = 1'b1;
        cycle();
        chk("s5_ien", 32'(bus.ien), 32'd1);
        chk("s5_irq", 32'(bus.irq), 32'd1);
        t_ack = 1'b1;
        cycle();
        chk("s5_ack_ien", 32'(bus.ien), 32'd0);
        chk("s5_ack_irq", 32'(bus.irq), 32'd0);
        idle(); t_ion = 1'b1;
        cycle();
        t_iof = 1'b1;
        cycle();
        chk("s5_iof_ien", 32'(bus.ien), 32'd0);
        idle();

        // random traffic
        for (int n = 0; n < 500; n++) begin
            t_rst       = ($urandom_range(0, 63) != 0);
            t_in_valid  = ($urandom_range(0, 1) == 1);
            t_in_data   = 8'($urandom);
            t_inp       = ($urandom_range(0, 2) == 0);
            t_out       = ($urandom_range(0, 2) == 0);
            t_wr_data   = 8'($urandom);
            t_out_ready = ($urandom_range(0, 1) == 1);
            t_ion       = ($urandom_range(0, 5) == 0);
            t_iof       = ($urandom_range(0, 9) == 0);
            t_ack       = ($urandom_range(0, 9) == 0);
            t_clr       = ($urandom_range(0, 7) == 0);
            cycle();
        end

        // load everything, then reset for one cycle
        idle(); t_rst = 1'b0;
        cycle();
        idle(); t_inp = 1'b1;
        cycle();
        idle();
        for (int i = 0; i < 5; i++) begin
            t_out = 1'b1; t_wr_data = 8'(i + 1);
            t_in_valid = 1'b1; t_in_data = 8'(8'h80 + i);
            t_ion = 1'b1;
            cycle();
        end
        idle();
        chk("s6_pre_ien", 32'(bus.ien), 32'd1);
        chk("s6_pre_ovf", 32'(bus.err_ovf), 32'd1);
        chk("s6_pre_udf", 32'(bus.err_udf), 32'd1);
        chk("s6_pre_in", 32'(bus.in_count), 32'd4);
        t_rst = 1'b0;
        cycle();
        idle();
        chk("s6_in_count", 32'(bus.in_count), 32'd0);
        chk("s6_out_count", 32'(bus.out_count), 32'd0);
        chk("s6_fgi", 32'(bus.fgi), 32'd0);
        chk("s6_fgo", 32'(bus.fgo), 32'd1);
        chk("s6_ien", 32'(bus.ien), 32'd0);
        chk("s6_irq", 32'(bus.irq), 32'd0);
        chk("s6_ovf", 32'(bus.err_ovf), 32'd0);
        chk("s6_udf", 32'(bus.err_udf), 32'd0);
        chk("s6_rd", 32'(bus.cpu_rd_data), 32'd0);
        chk("s6_out_data", 32'(bus.ext_out_data), 32'd0);
        chk("s6_ready", 32'(bus.ext_in_ready), 32'd1);
        chk("s6_valid", 32'(bus.ext_out_valid), 32'd0);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
